// File: rtl/lut_multiplier_seq_pkg.sv
// rtl/lut_multiplier_seq_pkg.sv - shared FSM encoding and step-count helpers
package lut_multiplier_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int steps(input int m);
    return m / 2;
  endfunction

  // One spare bit so the counter can hold STEPS itself after the final step.
  function automatic int step_w(input int m);
    return $clog2(m / 2) + 1;
  endfunction

endpackage

// File: rtl/lut_multiplier_seq_if.sv
// rtl/lut_multiplier_seq_if.sv - operand/product handshake bundle
interface lut_multiplier_seq_if #(
  parameter int N = 8,
  parameter int M = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [M-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [N+M-1:0] AB;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, AB
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, AB
  );
endinterface

// File: rtl/lut_multiplier_seq_lut_pp_2b.sv
// rtl/lut_multiplier_seq_lut_pp_2b.sv - A x 2-bit partial product from a 4-entry table
module lut_pp_2b #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [1:0]   sel_i,
  output logic [N+1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    case (sel_i)
      2'd0:    pp_o = '0;
      2'd1:    pp_o = {2'b00, a_i};
      2'd2:    pp_o = {1'b0, a_i, 1'b0};
      default: pp_o = {2'b00, a_i} + {1'b0, a_i, 1'b0};
    endcase
  end

endmodule

// File: rtl/lut_multiplier_seq.sv
// rtl/lut_multiplier_seq.sv - iterative unsigned multiplier, two B bits per clock
import lut_multiplier_seq_pkg::*;

module lut_multiplier_seq #(
  parameter int N          = 8,
  parameter int M          = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  lut_multiplier_seq_if.slave  bus
);

  localparam int STEPS = steps(M);
  localparam int SW    = step_w(M);
  localparam int W     = N + M;

  if ((M % 2) != 0 || M < 2 || N < 2) begin : g_bad_params
    $error("lut_multiplier_seq: M must be even and >= 2, N must be >= 2");
  end

  state_e        state_q;
  logic [N-1:0]  a_q;
  logic [M-1:0]  b_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  ab_q;
  logic [SW-1:0] step_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [N+1:0]  pp;
  logic [W-1:0]  acc_d;
  logic [M-1:0]  b_d;
  logic          last_step;

  lut_pp_2b #(.N(N)) u_pp (
    .a_i   (a_q),
    .sel_i (b_q[1:0]),
    .pp_o  (pp)
  );

  // Partial product is weighted by 4^step; acc is wide enough that no add can overflow.
  assign acc_d     = acc_q + (W'(pp) << {step_q, 1'b0});
  assign b_d       = b_q >> 2;
  assign last_step = (step_q == SW'(STEPS - 1)) || (EARLY_EXIT && (b_d == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      ab_q        <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            acc_q      <= '0;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          b_q    <= b_d;
          step_q <= step_q + 1'b1;
          if (last_step) begin
            ab_q        <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // in_ready only rises after this edge, so a same-cycle in_valid waits a cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.AB        = ab_q;

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// tb/tb_lut_multiplier_seq.sv - directed and randomized checks for lut_multiplier_seq
module tb_lut_multiplier_seq;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lut_multiplier_seq_if #(.N(8), .M(8))  b0 ();
  lut_multiplier_seq_if #(.N(8), .M(8))  b1 ();
  lut_multiplier_seq_if #(.N(6), .M(10)) b2 ();

  lut_multiplier_seq #(.N(8), .M(8), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  lut_multiplier_seq #(.N(8), .M(8), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  lut_multiplier_seq #(.N(6), .M(10), .EARLY_EXIT(1'b0)) u2 (.clk(clk), .reset(reset), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic op0(input int a, input int b, input int exp_lat, input int exp_ab, input string tag);
    int lat;
    b0.out_ready = 1'b1;
    b0.A = 8'(a);
    b0.B = 8'(b);
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(b0.in_ready), 64'd0);
    lat = 0;
    do begin tick(); lat++; end while (!b0.out_valid && lat < 40);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ab"}, 64'(b0.AB), 64'(exp_ab));
    tick();
    chk({tag, "_done1cyc"}, 64'(b0.out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(b0.in_ready), 64'd1);
  endtask

  task automatic op1(input int a, input int b, input int exp_lat, input int exp_ab, input string tag);
    int lat;
    b1.out_ready = 1'b1;
    b1.A = 8'(a);
    b1.B = 8'(b);
    b1.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!b1.out_valid && lat < 40);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ab"}, 64'(b1.AB), 64'(exp_ab));
    tick();
    chk({tag, "_done1cyc"}, 64'(b1.out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int ra;
    int rb;
    int hold;
    logic seen;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    b0.in_valid = 1'b0; b0.A = '0; b0.B = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.A = '0; b1.B = '0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.A = '0; b2.B = '0; b2.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", 64'(b0.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_ab", 64'(b0.AB), 64'd0);

    op0(13, 11, 4, 143, "m13x11");
    op0(255, 255, 4, 65025, "m255x255");
    op0(0, 200, 4, 0, "m0x200");

    // Backpressure: result held for 10 cycles while stray operands are offered.
    b0.out_ready = 1'b0;
    b0.A = 8'd7;
    b0.B = 8'd9;
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!b0.out_valid && lat < 40);
    chk("hold_lat", 64'(lat), 64'd4);
    chk("hold_ab", 64'(b0.AB), 64'd63);
    for (int c = 0; c < 10; c++) begin
      b0.in_valid = c[0];
      b0.A = 8'd99;
      b0.B = 8'd99;
      tick();
      chk("hold_valid", 64'(b0.out_valid), 64'd1);
      chk("hold_ab_stable", 64'(b0.AB), 64'd63);
      chk("hold_in_ready", 64'(b0.in_ready), 64'd0);
    end
    b0.A = 8'd3;
    b0.B = 8'd5;
    b0.in_valid = 1'b1;
    b0.out_ready = 1'b1;
    tick();
    chk("same_cyc_not_accepted", 64'(b0.in_ready), 64'd1);
    chk("same_cyc_valid_drop", 64'(b0.out_valid), 64'd0);
    tick();
    b0.in_valid = 1'b0;
    chk("next_cyc_accepted", 64'(b0.in_ready), 64'd0);
    lat = 0;
    do begin tick(); lat++; end while (!b0.out_valid && lat < 40);
    chk("m3x5_lat", 64'(lat), 64'd4);
    chk("m3x5_ab", 64'(b0.AB), 64'd15);
    tick();
    chk("m3x5_done1cyc", 64'(b0.out_valid), 64'd0);

    op1(100, 3, 1, 300, "ee_b3");
    op1(100, 0, 1, 0, "ee_b0");
    op1(100, 192, 4, 19200, "ee_b192");

    // Reset while the operation is at step 2 abandons it.
    b0.out_ready = 1'b1;
    b0.A = 8'd50;
    b0.B = 8'd60;
    b0.in_valid = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_rst_in_ready", 64'(b0.in_ready), 64'd1);
    chk("midrun_rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("midrun_rst_ab", 64'(b0.AB), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | b0.out_valid;
    end
    chk("midrun_no_result", 64'(seen), 64'd0);
    op0(6, 7, 4, 42, "m6x7");

    for (int i = 0; i < 500; i++) begin
      ra = int'($urandom_range(0, 63));
      rb = int'($urandom_range(0, 1023));
      b2.out_ready = 1'b0;
      b2.A = 6'(ra);
      b2.B = 10'(rb);
      b2.in_valid = 1'b1;
      tick();
      b2.in_valid = 1'b0;
      lat = 0;
      do begin
        b2.out_ready = 1'($urandom_range(0, 1));
        tick();
        lat++;
      end while (!b2.out_valid && lat < 40);
      b2.out_ready = 1'b0;
      chk("rnd_lat", 64'(lat), 64'd5);
      chk("rnd_ab", 64'(b2.AB), 64'(ra * rb));
      hold = int'($urandom_range(0, 3));
      repeat (hold) tick();
      chk("rnd_hold", 64'(b2.out_valid), 64'd1);
      b2.out_ready = 1'b1;
      tick();
      b2.out_ready = 1'b0;
      chk("rnd_release", 64'(b2.out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_multiplier_seq.md
Name: lut_multiplier_seq

Overview:
- Iterative unsigned N x M multiplier built on 2-bit lookup-table partial products.
- Consumes 2 bits of B per clock and accumulates shifted partial products, so wide operands cost no wide combinational multiplier.
- Valid/ready handshake on both input and output; results are held under backpressure.
- Optional early exit when the remaining B bits are zero.
- Sits between operand registers and downstream datapath logic in the lab arithmetic units.

Parameters:
- N, 8, width of operand A (>=2).
- M, 8, width of operand B (even, >=2).
- EARLY_EXIT, 0, 1 = finish as soon as unprocessed B bits are all zero; 0 = fixed latency.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A/B present.
- in_ready  output  1  block can accept operands.
- A  input  N  multiplicand, unsigned.
- B  input  M  multiplier, unsigned.
- out_valid  output  1  AB holds a finished product.
- out_ready  input  1  consumer accepts AB.
- AB  output  N+M  product A*B, unsigned, exact (no truncation).

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE; AB=0; out_valid=0; in_ready=1 after the edge.
  - Internal A/B/accumulator/step counter cleared.
  - Reset mid-RUN or mid-DONE abandons the operation; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: capture A into a_reg and B into b_reg, acc=0, step=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - acc += pp << (2*step), where pp = a_reg*b_reg[1:0], taken from the LUT {0, A, A<<1, A+(A<<1)}, width N+2.
    - b_reg >>= 2; step++.
    - Exit to DONE after the cycle where step==M/2-1, or, if EARLY_EXIT=1, after any cycle where the shifted b_reg becomes 0.
    - AB loads the final acc value on the transition into DONE.
  - DONE: out_valid=1, AB stable, in_ready=0. On out_valid&out_ready go to IDLE; out_valid drops on that edge.
- Latency:
  - Acceptance edge = E. out_valid is high after edge E+M/2 (EARLY_EXIT=0).
  - With EARLY_EXIT=1: out_valid is high after edge E+k, k = max(1, ceil(index of highest set pair of B)+1). B=0 gives k=1.
- Throughput:
  - No overlap; the next acceptance happens no earlier than the cycle after the output handshake.
  - Minimum period is M/2+2 cycles.
- Width rules:
  - acc is N+M bits; every partial add fits without overflow.
  - Max product (2^N-1)(2^M-1) is exact.
- Boundary cases:
  - in_valid held while busy: ignored; operands are sampled only when in_ready=1.
  - out_ready held high continuously: DONE lasts exactly 1 cycle.
  - out_ready low: AB and out_valid held indefinitely.
  - in_valid asserted in the same cycle out_ready completes DONE: not accepted (in_ready=0 that cycle); accepted one cycle later.
  - A=0 or B=0: AB=0; with EARLY_EXIT=0 the latency is unchanged.
- Forbidden parameter settings: odd M or N<2 must be caught by an elaboration-time check.

Decomposition:
- Shared package (mult_pkg):
  - State encoding enum {IDLE, RUN, DONE}.
  - Helper constant function steps(M)=M/2.
  - Step-counter width function clog2(M/2)+1.
- Sub-module lut_pp_2b #(N):
  - Combinational A x 2-bit LUT partial-product generator, output width N+2.
  - Instantiated once and reused every cycle.
- Top module holds the FSM, shift register, counter and accumulator.

Test Plan:
- N=M=8, EARLY_EXIT=0, reset then A=13, B=11 with out_ready=1 → out_valid exactly 4 cycles after acceptance, AB=143, single-cycle DONE, in_ready back high the next cycle.
- A=255, B=255 → AB=65025; then A=0, B=200 → AB=0 with the same 4-cycle latency.
- A=7, B=9, out_ready=0 for 10 cycles after out_valid → AB=63 and out_valid held steady; in_valid pulses with other operands during the hold are ignored; after out_ready=1, the next accepted op is A=3, B=5 → AB=15.
- EARLY_EXIT=1, A=100, B=3 → out_valid 1 cycle after acceptance, AB=300; B=0 → 1 cycle, AB=0; B=192 → 4 cycles, AB=19200.
- Reset asserted for 1 cycle during RUN (step=2) of A=50, B=60 → next cycle in_ready=1, out_valid=0, AB=0; the following op A=6, B=7 → AB=42.
- N=6, M=10, randomized 500 ops with random out_ready backpressure → every AB equals A*B, and latency is always 5 cycles to out_valid.
